line_decoder_arbiter: RTL and testbench
=======================================

# line_decoder_arbiter

Round-robin arbiter and sequencer that shares one `Line_Decoder` (3-to-8, active-high Enable) among four requesters. Each requester presents a 3-bit line address. A grant drives the decoder's Enable, A, B, C for a fixed hold time. The block sits directly in front of the decoder: its Enable/A/B/C outputs wire straight to the decoder inputs, and it owns the decoder exclusively.

## Interface
- HOLD_CYCLES, 4: cycles Enable stays high per grant; legal range 1..256.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request per requester; bit i is requester i.
- addr  input  12  packed line addresses; addr[3i+2:3i] belongs to requester i, with MSB→A, LSB→C.
- gnt  output  4  one-hot grant, high for the whole hold window of the winner.
- done  output  1  one-cycle pulse on the last Enable cycle of a grant.
- busy  output  1  high in any non-IDLE state.
- Enable  output  1  to decoder Enable.
- A, B, C  output  1 each  to decoder select; A is the MSB.

## Operation
- States:
  - IDLE: Enable=0, gnt=0.
  - HOLD: Enable=1, gnt one-hot.
  - GAP: only with the macro; Enable=0, gnt=0, busy=1.
- Arbitration point: req is sampled only at an arbitration point; combinational pick, registered at the clock edge. Arbitration points are:
  - IDLE,
  - the final HOLD cycle (macro off),
  - GAP (macro on).
- Priority: round-robin pointer `ptr` (2 bits). The search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4). After granting requester i, ptr becomes (i+1) mod 4.
- Address capture: on grant, the winner's addr slice is latched into {A,B,C}. Later addr changes are ignored until the next grant.
- Non-preemptive: once granted, HOLD runs its full HOLD_CYCLES even if the winner's req drops. A new req from any requester, at any priority, waits.
- Transitions (macro off):
  - IDLE→HOLD if any req.
  - HOLD stays HOLD while count < HOLD_CYCLES−1.
  - Final HOLD cycle → HOLD (new grant, count=0) if any req; otherwise → IDLE.
- Transitions (macro on):
  - Final HOLD cycle → GAP.
  - GAP → HOLD if any req; otherwise → IDLE.
- Hold counter: width max(1,$clog2(HOLD_CYCLES)). It is cleared on every grant and must not wrap inside a window.
- A requester that keeps req high through its own final HOLD cycle is re-eligible. It wins again only if no other requester sits ahead of it in round-robin order.

## Timing
- Reset values:
  - Enable=0, A=B=C=0, gnt=0, done=0, busy=0.
  - ptr=0 (requester 0 highest), count=0, state=IDLE.
- Reset mid-HOLD: at the next edge all outputs return to their reset values; the grant is lost and no done pulse is issued.
- Latency: req rising in IDLE at edge k produces Enable=1, gnt and {A,B,C} valid from edge k+1.
- Enable is high for exactly HOLD_CYCLES consecutive cycles per grant. done coincides with the last of them.
- Back-to-back (macro off): the next grant's Enable follows with no low cycle. gnt and {A,B,C} switch on the same edge, so Enable stays continuously 1.
- HOLD_CYCLES=1: every HOLD cycle is final, and done is high in every HOLD cycle.
- All outputs are registered; there is no combinational path from req or addr to any output.

## Configuration
- LINE_DECODER_ARB_GAP_EN:
  - Defined: a one-cycle GAP state follows every grant, giving break-before-make with at least one Enable=0 cycle between grants. Throughput is one grant per HOLD_CYCLES+1 cycles.
  - Undefined: no GAP state; grants run back-to-back at one grant per HOLD_CYCLES cycles.

## Test plan
- Reset → req=4'b0001, addr[2:0]=3'b101 at edge 1 → from edge 2: gnt=0001, {A,B,C}=101, Enable=1 for 4 cycles, done on the 4th, then IDLE with busy=0.
- req=4'b1111 held, addr slices 0..3 = 000/011/110/111 → grants in order 0,1,2,3,0. Macro off: Enable continuously 1. Macro on: one Enable=0 cycle between grants.
- Grant requester 2, then drop req[2] after 1 cycle → Enable stays high the full 4 cycles and done pulses once.
- Grant requester 1 with addr=3'b010; change addr to 3'b111 mid-hold → {A,B,C} stays 010 until done.
- Assert reset in the 2nd HOLD cycle → next edge: Enable=0, gnt=0, done=0, ptr=0. A following req=4'b1001 grants requester 0 first.
- HOLD_CYCLES=1, req=4'b0110 → gnt alternates 0010, 0100; done=1 every HOLD cycle.

Source files
------------

// File: rtl/line_decoder_arbiter.sv
// line_decoder_arbiter
//   Round-robin arbiter/sequencer that shares one 3-to-8 line decoder
//   (active-high Enable) among four requesters. A winner owns the decoder
//   for HOLD_CYCLES cycles. Its 3-bit line address drives {A,B,C}, with A as the MSB.
//
//   Optional feature: define LINE_DECODER_ARB_GAP_EN to insert a one-cycle
//   GAP (Enable=0) after every grant for break-before-make. When the macro is
//   undefined, grants run back-to-back with Enable held continuously high.
//
// Parameters
//   HOLD_CYCLES  cycles Enable stays high per grant (1..256)
// Ports
//   clk      rising-edge clock
//   reset    synchronous, active-high reset
//   req[3:0] request per requester (bit i = requester i)
//   addr     packed line addresses, addr[3i+2:3i] for requester i
//   gnt      one-hot grant, high for the whole hold window
//   done     one-cycle pulse on the last Enable cycle of a grant
//   busy     high in any non-IDLE state
//   Enable   decoder enable
//   A, B, C  decoder select lines (A = MSB)
module line_decoder_arbiter #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [11:0] addr,
  output logic [3:0]  gnt,
  output logic        done,
  output logic        busy,
  output logic        Enable,
  output logic        A,
  output logic        B,
  output logic        C
);

  localparam int unsigned CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   count, count_n;
  logic [1:0]      ptr, ptr_n;
  logic [3:0]      gnt_n;
  logic [2:0]      sel, sel_n;
  logic [3:0][2:0] addr_v;
  logic            found;
  logic [1:0]      win;
  logic [1:0]      idx;
  logic            last;
  logic            arb_point;

  assign addr_v = addr;

  // Round-robin search starting at ptr; the first asserted request wins.
  always_comb begin
    found = 1'b0;
    win   = ptr;
    idx   = ptr;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign last = (state == HOLD) && (count == LAST);

`ifdef LINE_DECODER_ARB_GAP_EN
  assign arb_point = (state == IDLE) || (state == GAP);
`else
  assign arb_point = (state == IDLE) || last;
`endif

  always_comb begin
    state_n = state;
    count_n = count;
    ptr_n   = ptr;
    gnt_n   = gnt;
    sel_n   = sel;
    if (arb_point && found) begin
      state_n = HOLD;
      count_n = '0;
      ptr_n   = win + 2'd1;
      gnt_n   = 4'b0001 << win;
      sel_n   = addr_v[win];
    end else begin
      case (state)
        HOLD: begin
          if (!last) begin
            count_n = count + 1'b1;
          end else begin
`ifdef LINE_DECODER_ARB_GAP_EN
            state_n = GAP;
`else
            state_n = IDLE;
`endif
            count_n = '0;
            gnt_n   = '0;
          end
        end
        GAP: begin
          state_n = IDLE;
          gnt_n   = '0;
        end
        default: begin
          state_n = IDLE;
          gnt_n   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next-state values so each one lines up
  // with the state it describes, with no combinational path from req/addr.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      ptr    <= '0;
      gnt    <= '0;
      sel    <= '0;
      Enable <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      ptr    <= ptr_n;
      gnt    <= gnt_n;
      sel    <= sel_n;
      Enable <= (state_n == HOLD);
      busy   <= (state_n != IDLE);
      done   <= (state_n == HOLD) && (count_n == LAST);
    end
  end

  assign A = sel[2];
  assign B = sel[1];
  assign C = sel[0];

endmodule

// File: tb/tb_line_decoder_arbiter.sv
// Directed testbench for line_decoder_arbiter (default build, no GAP state).
// dut uses HOLD_CYCLES=4, dut1 uses HOLD_CYCLES=1; they share clk and reset.
// Observation vector layout: {gnt[3:0], Enable, busy, done, A, B, C}.
module tb_line_decoder_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req, req1;
  logic [11:0] addr, addr1;
  logic [3:0]  gnt, gnt1;
  logic        done, done1, busy, busy1;
  logic        en, en1, a, b, c, a1, b1, c1;
  logic [9:0]  obs, obs1;
  logic [9:0]  exp_v;
  int          checks;
  int          passes;

  line_decoder_arbiter #(.HOLD_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .req(req), .addr(addr),
    .gnt(gnt), .done(done), .busy(busy), .Enable(en),
    .A(a), .B(b), .C(c)
  );

  line_decoder_arbiter #(.HOLD_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .req(req1), .addr(addr1),
    .gnt(gnt1), .done(done1), .busy(busy1), .Enable(en1),
    .A(a1), .B(b1), .C(c1)
  );

  assign obs  = {gnt, en, busy, done, a, b, c};
  assign obs1 = {gnt1, en1, busy1, done1, a1, b1, c1};

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req   = '0;
    req1  = '0;
    addr  = '0;
    addr1 = '0;
    tick();
    tick();
    checks++;
    if (obs !== 10'b0) $display("FAIL reset_dut got=%b exp=%b", obs, 10'b0);
    else passes++;
    checks++;
    if (obs1 !== 10'b0) $display("FAIL reset_dut1 got=%b exp=%b", obs1, 10'b0);
    else passes++;
    reset = 1'b0;
  endtask

  task automatic test_single;
    req  = 4'b0001;
    addr = 12'b000_000_000_101;
    tick();
    req = '0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (cyc != 0) tick();
      exp_v = {4'b0001, 1'b1, 1'b1, (cyc == 3), 3'b101};
      checks++;
      if (obs !== exp_v) $display("FAIL single_c%0d got=%b exp=%b", cyc, obs, exp_v);
      else passes++;
    end
    tick();
    checks++;
    if (obs[9:3] !== 7'b0) $display("FAIL single_idle got=%b exp=%b", obs[9:3], 7'b0);
    else passes++;
  endtask

  task automatic test_round_robin;
    logic [2:0] slice [4];
    slice[0] = 3'b000;
    slice[1] = 3'b011;
    slice[2] = 3'b110;
    slice[3] = 3'b111;
    // restart with ptr=0 so requester 0 is first
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req  = 4'b1111;
    addr = {3'b111, 3'b110, 3'b011, 3'b000};
    for (int cyc = 0; cyc < 20; cyc++) begin
      tick();
      exp_v = {4'b0001 << ((cyc / 4) % 4), 1'b1, 1'b1, ((cyc % 4) == 3),
               slice[(cyc / 4) % 4]};
      checks++;
      if (obs !== exp_v) $display("FAIL rr_c%0d got=%b exp=%b", cyc, obs, exp_v);
      else passes++;
    end
    req = '0;
    tick();
    checks++;
    if (obs[9:3] !== 7'b0) $display("FAIL rr_idle got=%b exp=%b", obs[9:3], 7'b0);
    else passes++;
  endtask

  task automatic test_no_preempt;
    int pulses;
    pulses = 0;
    // ptr is 1 here; only requester 2 asks
    req  = 4'b0100;
    addr = {3'b000, 3'b100, 3'b000, 3'b000};
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      if (cyc == 0) req = '0;
      if (done === 1'b1) pulses++;
      exp_v = {4'b0100, 1'b1, 1'b1, (cyc == 3), 3'b100};
      checks++;
      if (obs !== exp_v) $display("FAIL nopre_c%0d got=%b exp=%b", cyc, obs, exp_v);
      else passes++;
    end
    tick();
    if (done === 1'b1) pulses++;
    checks++;
    if (pulses != 1) $display("FAIL nopre_pulses got=%0d exp=1", pulses);
    else passes++;
    checks++;
    if (obs[9:3] !== 7'b0) $display("FAIL nopre_idle got=%b exp=%b", obs[9:3], 7'b0);
    else passes++;
  endtask

  task automatic test_addr_capture;
    req  = 4'b0010;
    addr = {3'b000, 3'b000, 3'b010, 3'b000};
    tick();
    req  = '0;
    addr = {3'b111, 3'b111, 3'b111, 3'b111};
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (cyc != 0) tick();
      exp_v = {4'b0010, 1'b1, 1'b1, (cyc == 3), 3'b010};
      checks++;
      if (obs !== exp_v) $display("FAIL capture_c%0d got=%b exp=%b", cyc, obs, exp_v);
      else passes++;
    end
    tick();
    checks++;
    if (obs[9:3] !== 7'b0) $display("FAIL capture_idle got=%b exp=%b", obs[9:3], 7'b0);
    else passes++;
  endtask

  task automatic test_reset_mid_hold;
    // ptr is 2 here; requester 0 is the only one asking
    req  = 4'b0001;
    addr = '0;
    tick();
    req = '0;
    tick();
    exp_v = {4'b0001, 1'b1, 1'b1, 1'b0, 3'b000};
    checks++;
    if (obs !== exp_v) $display("FAIL midrst_hold2 got=%b exp=%b", obs, exp_v);
    else passes++;
    reset = 1'b1;
    tick();
    checks++;
    if (obs !== 10'b0) $display("FAIL midrst_clear got=%b exp=%b", obs, 10'b0);
    else passes++;
    reset = 1'b0;
    req   = 4'b1001;
    addr  = {3'b110, 3'b000, 3'b000, 3'b001};
    for (int cyc = 0; cyc < 8; cyc++) begin
      tick();
      if (cyc == 4) req = '0;
      if (cyc < 4) exp_v = {4'b0001, 1'b1, 1'b1, (cyc == 3), 3'b001};
      else         exp_v = {4'b1000, 1'b1, 1'b1, (cyc == 7), 3'b110};
      checks++;
      if (obs !== exp_v) $display("FAIL midrst_c%0d got=%b exp=%b", cyc, obs, exp_v);
      else passes++;
    end
    tick();
    checks++;
    if (obs[9:3] !== 7'b0) $display("FAIL midrst_idle got=%b exp=%b", obs[9:3], 7'b0);
    else passes++;
  endtask

  task automatic test_hold_one;
    req1  = 4'b0110;
    addr1 = {3'b000, 3'b100, 3'b011, 3'b000};
    for (int cyc = 0; cyc < 4; cyc++) begin
      tick();
      if (cyc == 3) req1 = '0;
      if ((cyc % 2) == 0) exp_v = {4'b0010, 1'b1, 1'b1, 1'b1, 3'b011};
      else                exp_v = {4'b0100, 1'b1, 1'b1, 1'b1, 3'b100};
      checks++;
      if (obs1 !== exp_v) $display("FAIL hold1_c%0d got=%b exp=%b", cyc, obs1, exp_v);
      else passes++;
    end
    tick();
    checks++;
    if (obs1[9:3] !== 7'b0) $display("FAIL hold1_idle got=%b exp=%b", obs1[9:3], 7'b0);
    else passes++;
  endtask

  initial begin
    clk    = 1'b0;
    checks = 0;
    passes = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_no_preempt();
    test_addr_capture();
    test_reset_mid_hold();
    test_hold_one();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
